// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Tagged, direct-mapped branch target buffer with per-entry
//                saturating direction counters and saturating performance
//                counters.
//                The lookup port is purely combinational and is used for the
//                IF-stage prediction. The update port is written by resolved
//                conditional branches in ID/EX.
//  Ports       : clk, rst                      - clock, sync active-high reset
//                lookup_pc                     - PC of the instruction in IF
//                pred_hit/pred_taken/pred_target - prediction outputs
//                upd_valid/upd_pc/upd_target/upd_taken/upd_pred_taken
//                                              - resolved-branch update
//                flush                         - invalidate all entries
//                stat_updates/stat_mispredicts - saturating statistics
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int N_ENTRIES = 16,
  parameter int PC_W      = 64,
  parameter int TAG_W     = 8,
  parameter int CNT_W     = 2,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic              flush,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  // Weakly-taken allocation value: only the MSB set (1 when CNT_W == 1).
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(1) << (CNT_W - 1);
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  logic             valid_q  [N_ENTRIES];
  logic             valid_d  [N_ENTRIES];
  logic [TAG_W-1:0] tag_q    [N_ENTRIES];
  logic [TAG_W-1:0] tag_d    [N_ENTRIES];
  logic [PC_W-1:0]  target_q [N_ENTRIES];
  logic [PC_W-1:0]  target_d [N_ENTRIES];
  logic [CNT_W-1:0] cnt_q    [N_ENTRIES];
  logic [CNT_W-1:0] cnt_d    [N_ENTRIES];

  logic [STAT_W-1:0] stat_updates_q, stat_updates_d;
  logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit;

  // Word-aligned PCs: bits [1:0] and bits above the tag do not take part in
  // the decode. Folding them here keeps the intent explicit.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign lk_idx = lookup_pc[2 +: IDX_W];
  assign lk_tag = lookup_pc[2 + IDX_W +: TAG_W];
  assign up_idx = upd_pc[2 +: IDX_W];
  assign up_tag = upd_pc[2 + IDX_W +: TAG_W];

  // Lookup reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && cnt_q[lk_idx][CNT_W-1];
    pred_target = pred_hit ? target_q[lk_idx] : '0;
  end

  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // Flush wins over a coincident update; only valid bits are cleared.
      for (int i = 0; i < N_ENTRIES; i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
          if (cnt_q[up_idx] != CNT_MAX) begin
            cnt_d[up_idx] = cnt_q[up_idx] + CNT_W'(1);
          end
        end else if (cnt_q[up_idx] != '0) begin
          cnt_d[up_idx] = cnt_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Taken miss replaces whatever lives at this index.
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        cnt_d[up_idx]    = CNT_INIT;
      end
    end
  end

  // Statistics count every resolved update, flushed or not, and stick at max.
  always_comb begin
    stat_updates_d     = stat_updates_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid) begin
      if (stat_updates_q != STAT_MAX) begin
        stat_updates_d = stat_updates_q + STAT_W'(1);
      end
      if ((upd_pred_taken != upd_taken) && (stat_mispredicts_q != STAT_MAX)) begin
        stat_mispredicts_d = stat_mispredicts_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      cnt_q              <= cnt_d;
      stat_updates_q     <= stat_updates_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_target_buffer
//  Description : Self-checking bench for branch_target_buffer. A table of
//                update/lookup vectors with expected lookup results is applied
//                one per cycle; expected values (plus reference statistics)
//                are queued when driven and compared on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_target_buffer;

  localparam int N_ENTRIES = 16;
  localparam int PC_W      = 64;
  localparam int TAG_W     = 8;
  localparam int CNT_W     = 2;
  localparam int STAT_W    = 4;
  localparam int STAT_MAX  = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC_W-1:0]   lookup_pc = '0;
  logic              pred_hit, pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              upd_valid = 1'b0;
  logic [PC_W-1:0]   upd_pc = '0;
  logic [PC_W-1:0]   upd_target = '0;
  logic              upd_taken = 1'b0;
  logic              upd_pred_taken = 1'b0;
  logic              flush = 1'b0;
  logic [STAT_W-1:0] stat_updates, stat_mispredicts;

  branch_target_buffer #(
    .N_ENTRIES(N_ENTRIES), .PC_W(PC_W), .TAG_W(TAG_W),
    .CNT_W(CNT_W), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken), .flush(flush),
    .stat_updates(stat_updates), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            uv;
    logic [PC_W-1:0] upc;
    logic [PC_W-1:0] utgt;
    logic            ut;
    logic            upt;
    logic            fl;
    logic [PC_W-1:0] lpc;
    logic            eh;
    logic            et;
    logic [PC_W-1:0] etgt;
  } vec_t;

  typedef struct {
    logic            hit;
    logic            taken;
    logic [PC_W-1:0] target;
    int              su;
    int              sm;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_upd  = 0;
  int   m_mis  = 0;

  function automatic vec_t mk(logic uv, logic [PC_W-1:0] upc, logic [PC_W-1:0] utgt,
                              logic ut, logic upt, logic fl, logic [PC_W-1:0] lpc,
                              logic eh, logic et, logic [PC_W-1:0] etgt);
    vec_t v;
    v.uv = uv; v.upc = upc; v.utgt = utgt; v.ut = ut; v.upt = upt;
    v.fl = fl; v.lpc = lpc; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  // Drive one cycle; when chk is set the expected lookup (pre-update state)
  // and the reference statistics before this cycle are queued.
  task automatic drive(input vec_t v, input logic r, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; upd_valid = v.uv; upd_pc = v.upc; upd_target = v.utgt;
    upd_taken = v.ut; upd_pred_taken = v.upt; flush = v.fl; lookup_pc = v.lpc;
    if (chk) begin
      e.hit = v.eh; e.taken = v.et; e.target = v.etgt; e.su = m_upd; e.sm = m_mis;
      sb.push_back(e);
    end
    if (r) begin
      m_upd = 0; m_mis = 0;
    end else if (v.uv) begin
      if (m_upd < STAT_MAX) m_upd++;
      if ((v.upt != v.ut) && (m_mis < STAT_MAX)) m_mis++;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (pred_hit !== e.hit) begin
        errors++; $display("FAIL pred_hit got %0b want %0b at %0t", pred_hit, e.hit, $time);
      end
      checks++;
      if (pred_taken !== e.taken) begin
        errors++; $display("FAIL pred_taken got %0b want %0b at %0t", pred_taken, e.taken, $time);
      end
      checks++;
      if (pred_target !== e.target) begin
        errors++; $display("FAIL pred_target got %0h want %0h at %0t", pred_target, e.target, $time);
      end
      checks++;
      if (stat_updates !== STAT_W'(e.su)) begin
        errors++; $display("FAIL stat_updates got %0d want %0d at %0t", stat_updates, e.su, $time);
      end
      checks++;
      if (stat_mispredicts !== STAT_W'(e.sm)) begin
        errors++; $display("FAIL stat_mispredicts got %0d want %0d at %0t", stat_mispredicts, e.sm, $time);
      end
    end
  end

  vec_t tbl[23];
  vec_t idle;

  initial begin
    //          uv  upc     utgt     ut  upt fl  lpc     eh  et  etgt
    tbl[0]  = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 0, 0, 64'h000); // reset state
    tbl[1]  = mk(1, 64'h40, 64'h100, 1, 1, 0, 64'h40, 0, 0, 64'h000); // no bypass
    tbl[2]  = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 1, 1, 64'h100); // allocated cnt=2
    tbl[3]  = mk(1, 64'h40, 64'h100, 1, 1, 0, 64'h40, 1, 1, 64'h100); // -> 3
    tbl[4]  = mk(1, 64'h40, 64'h100, 1, 1, 0, 64'h40, 1, 1, 64'h100); // stays 3
    tbl[5]  = mk(1, 64'h40, 64'h999, 0, 0, 0, 64'h40, 1, 1, 64'h100); // -> 2, no tgt write
    tbl[6]  = mk(1, 64'h40, 64'h000, 0, 0, 0, 64'h40, 1, 1, 64'h100); // -> 1
    tbl[7]  = mk(1, 64'h40, 64'h000, 0, 0, 0, 64'h40, 1, 0, 64'h100); // -> 0
    tbl[8]  = mk(1, 64'h40, 64'h000, 0, 1, 0, 64'h40, 1, 0, 64'h100); // stays 0, mispredict
    tbl[9]  = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 1, 0, 64'h100);
    tbl[10] = mk(1, 64'h80, 64'h000, 0, 0, 0, 64'h40, 1, 0, 64'h100); // alias NT: no alloc
    tbl[11] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h80, 0, 0, 64'h000);
    tbl[12] = mk(1, 64'h80, 64'h200, 1, 1, 0, 64'h40, 1, 0, 64'h100); // alias T: replace
    tbl[13] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 0, 0, 64'h000);
    tbl[14] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h80, 1, 1, 64'h200);
    tbl[15] = mk(1, 64'h80, 64'h300, 1, 1, 0, 64'h80, 1, 1, 64'h200); // taken hit: new tgt
    tbl[16] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h80, 1, 1, 64'h300);
    tbl[17] = mk(1, 64'h44, 64'h500, 1, 0, 0, 64'h44, 0, 0, 64'h000); // alloc, mispredict
    tbl[18] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h44, 1, 1, 64'h500);
    tbl[19] = mk(1, 64'h48, 64'h600, 1, 1, 1, 64'h80, 1, 1, 64'h300); // flush + update
    tbl[20] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h80, 0, 0, 64'h000);
    tbl[21] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h44, 0, 0, 64'h000);
    tbl[22] = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h48, 0, 0, 64'h000); // update discarded
    idle = mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 0, 0, 64'h000);

    drive(idle, 1'b1, 1'b0);
    drive(idle, 1'b1, 1'b0);
    for (int i = 0; i < 23; i++) drive(tbl[i], 1'b0, 1'b1);

    // Reset mid-operation drops a coincident update and clears the stats.
    drive(mk(1, 64'h40, 64'h700, 1, 1, 0, 64'h40, 0, 0, 64'h000), 1'b0, 1'b1);
    drive(mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 1, 1, 64'h700), 1'b0, 1'b1);
    drive(mk(1, 64'h40, 64'h800, 1, 0, 1, 64'h40, 0, 0, 64'h000), 1'b1, 1'b0);
    drive(mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h40, 0, 0, 64'h000), 1'b0, 1'b1);

    // Statistics saturation: 20 mispredicted not-taken updates (never allocated).
    for (int i = 0; i < 20; i++)
      drive(mk(1, 64'h4c, 64'h900, 0, 1, 0, 64'h4c, 0, 0, 64'h000), 1'b0, 1'b1);
    drive(mk(0, 64'h00, 64'h000, 0, 0, 0, 64'h4c, 0, 0, 64'h000), 1'b0, 1'b1);
    checks++;
    if (m_upd != STAT_MAX || m_mis != STAT_MAX) begin
      errors++; $display("FAIL ref_stats got %0d/%0d want %0d/%0d", m_upd, m_mis, STAT_MAX, STAT_MAX);
    end

    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
- Parametrised, tagged branch target buffer with per-entry saturating direction counters; supersedes the untagged 4-entry prediction table.
- Lookup port is read combinationally in IF for prediction. Update port is written in ID/EX on resolved conditional branches.
- Adds tag match, configurable depth and counter width, explicit update PC, a flush, and saturating performance counters.

Parameters:
- N_ENTRIES, 16: number of entries; power of 2, ≥2.
- PC_W, 64: PC width.
- TAG_W, 8: stored tag bits; TAG_W ≤ PC_W-2-log2(N_ENTRIES).
- CNT_W, 2: direction counter width, ≥1.
- STAT_W, 32: performance counter width.

Ports:
- clk, in, 1: clock, all state on rising edge.
- rst, in, 1: synchronous, active-high reset.
- lookup_pc, in, PC_W: PC of the instruction in IF.
- pred_hit, out, 1: valid entry with matching tag.
- pred_taken, out, 1: predict taken.
- pred_target, out, PC_W: predicted target.
- upd_valid, in, 1: resolved conditional branch this cycle.
- upd_pc, in, PC_W: PC of the resolved branch.
- upd_target, in, PC_W: computed branch target.
- upd_taken, in, 1: actual outcome.
- upd_pred_taken, in, 1: prediction originally made for this branch.
- flush, in, 1: invalidate all entries.
- stat_updates, out, STAT_W: count of upd_valid cycles.
- stat_mispredicts, out, STAT_W: count of mispredicted updates.

Behaviour:
- Field decode:
  - IDX_W = log2(N_ENTRIES).
  - index = pc[2+IDX_W-1:2].
  - tag = pc[2+IDX_W+TAG_W-1:2+IDX_W].
  - The same decode applies to lookup_pc and upd_pc.
- Per-entry state: valid (1b), tag (TAG_W), target (PC_W), counter (CNT_W).
- Lookup is purely combinational, 0-cycle latency:
  - pred_hit = valid[i] & (tag[i]==lookup tag).
  - pred_taken = pred_hit & counter[i][CNT_W-1].
  - pred_target = pred_hit ? target[i] : 0.
- Same-cycle update and lookup on the same index: lookup returns pre-update state. There is no bypass.
- Update, when upd_valid=1 and flush=0, with i = upd index:
  - Hit (valid and tag match):
    - Counter increments if upd_taken, decrements otherwise.
    - Counter saturates at 2^CNT_W-1 and at 0.
    - Target is overwritten with upd_target only if upd_taken.
  - Miss and upd_taken=1: allocate or replace the entry unconditionally.
    - valid=1, tag=upd tag, target=upd_target.
    - counter = 2^(CNT_W-1), i.e. weakly taken.
  - Miss and upd_taken=0: entry unchanged. Not-taken branches are never allocated.
- Flush:
  - flush=1 clears every valid bit next cycle.
  - Tags, targets and counters are retained but irrelevant.
  - flush has priority over a same-cycle update: the update is discarded for the tables.
  - The update is still counted in the stats.
- Stats:
  - On upd_valid=1 (regardless of flush), stat_updates increments.
  - stat_mispredicts increments if upd_pred_taken != upd_taken.
  - Both saturate at all-ones (no wrap).
  - Stats are not cleared by flush.
- Reset (rst=1 at clk edge):
  - All valid=0, counters=0, targets=0, tags=0.
  - Both stats=0.
  - Hence pred_hit=0, pred_taken=0, pred_target=0 for any lookup_pc.
  - rst overrides flush and update in the same cycle. Reset mid-operation drops all in-flight updates.
- CNT_W=1 degenerates to last-outcome prediction; allocation sets counter=1.

Test Plan:
- Reset, then lookup_pc=0x40 -> pred_hit=0, pred_taken=0, pred_target=0; stats=0.
- Update pc=0x40, taken, target=0x100 -> next cycle lookup 0x40: hit=1, taken=1 (counter=2), target=0x100.
- Counter saturation (same entry):
  - Two further taken updates -> counter=3.
  - Three not-taken updates -> counter=0, pred_taken=0, hit=1, target still 0x100.
  - A fourth not-taken update -> counter stays 0.
- Aliasing: with N_ENTRIES=16, TAG_W=8, update pc=0x40+0x40 (same index, different tag) not-taken -> no allocation, lookup 0x40 still hits. Same pc taken with target=0x200 -> replaces the entry; lookup 0x40 misses, lookup 0x80 hits with target 0x200.
- Flush vs. update: flush=1 together with an update pc=0x44 taken -> all lookups miss next cycle; stat_updates increments.
- Stats saturation: STAT_W=4, 20 updates each with upd_pred_taken != upd_taken -> stat_updates=15, stat_mispredicts=15.
